wb_commit: RTL and testbench
============================

# wb_commit

Writeback commit block: the consumer end of the MEM/WB pipeline register. It owns the 32×32 general-purpose register file, the HI/LO pair and the LLbit, and commits the `wb_*` bundle into them on each rising edge. It provides two GPR read ports to decode plus HI/LO/LLbit read-outs to execute/mem. Same-cycle write-to-read bypass is provided where configured.

## Interface
Parameters:
- `NREGS`, 32: GPR count; address width is log2(NREGS).
- `DW`, 32: data width of GPRs, HI and LO.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wb_wd` in 5: GPR write address.
- `wb_wreg` in 1: GPR write enable.
- `wb_wdata` in 32: GPR write data.
- `wb_whilo` in 1: HI/LO write enable; writes both registers together.
- `wb_hi` in 32: HI write data.
- `wb_lo` in 32: LO write data.
- `wb_LLbit_we` in 1: LLbit write enable.
- `wb_LLbit_value` in 1: LLbit write data.
- `flush` in 1: exception/eret flush; clears LLbit.
- `re1` in 1: read port 1 enable.
- `raddr1` in 5: read port 1 address.
- `rdata1` out 32: read port 1 data.
- `re2` in 1: read port 2 enable.
- `raddr2` in 5: read port 2 address.
- `rdata2` out 32: read port 2 data.
- `hi_o` out 32: current HI value.
- `lo_o` out 32: current LO value.
- `LLbit_o` out 1: current LLbit.

## Operation
- GPR write: on a rising edge with `wb_wreg`=1 and `wb_wd`≠0, `regs[wb_wd]` is updated to `wb_wdata`.
  - Writes to `$0` are discarded.
  - `$0` always reads 0.
- HI/LO: on a rising edge with `wb_whilo`=1, `hi`←`wb_hi` and `lo`←`wb_lo`. There is no partial write.
- LLbit update, evaluated at the rising edge:
  - `flush`=1 forces 0. This has priority over `wb_LLbit_we`.
  - Otherwise, `wb_LLbit_we`=1 loads `wb_LLbit_value`.
  - Otherwise the LLbit holds.
- Read port n (combinational):
  - `ren`=0 gives 0.
  - `raddrn`=0 gives 0.
  - With bypass compiled in, if `wb_wreg`=1 and `wb_wd`==`raddrn` (nonzero), the port returns `wb_wdata`.
  - Otherwise the port returns `regs[raddrn]`.
- HI/LO/LLbit outputs:
  - With bypass compiled in, they show the pending write value when the corresponding enable is asserted.
  - For `LLbit_o` the priority is `flush`→0, then `wb_LLbit_we`→`wb_LLbit_value`.
  - Without bypass, they show the stored registers.
- A bundle of all zeros (pipeline bubble or MEM/WB flush) causes no state change.

## Timing
- Reset: asserting `rst_n`=0 clears all GPRs, `hi`, `lo` and LLbit to 0 immediately, with no clock needed. All outputs are 0 while reset is held.
- Reset deassertion is synchronised by the caller. The first write is accepted on the first rising edge with `rst_n`=1.
- Reset mid-write: reset wins, and the write is lost.
- Write latency is one edge: stored state changes at the edge that samples the enable.
  - With bypass, readers see the new value in the same cycle.
  - Without bypass, readers see it in the next cycle.
- Simultaneous events:
  - Both read ports may hit the same address as the write; both get `wb_wdata`.
  - `flush` and `wb_LLbit_we` in the same cycle: LLbit=0.
  - `wb_whilo` together with `wb_wreg`: both commit independently.
- Back-to-back writes to the same register: the last edge wins. No hazard exists inside the block.

## Configuration
- `WB_BYPASS_EN` defined: the same-cycle write-through muxes on `rdata1`, `rdata2`, `hi_o`, `lo_o` and `LLbit_o` are present.
- `WB_BYPASS_EN` undefined:
  - Outputs come straight from storage.
  - Decode must stall one extra cycle on a WB read-after-write; the hazard unit handles this.
  - The area and timing of the read path shrink.

## Structure
- Shared package `cpu_pkg` holds:
  - `REG_ADDR_W`=5.
  - `ZERO_REG`=5'd0.
  - `WORD_ZERO`=32'h0.
  - Typedef `word_t` (32-bit).
  - Typedef `reg_addr_t`.
- One sub-module, `regfile_2r1w`, contains the GPR array, the `$0` masking, the read enables and the bypass.
- HI/LO and LLbit stay in the `wb_commit` top.

## Test plan
- Reset: drive `rst_n`=0 asynchronously mid-cycle after writes → `rdata1`/`rdata2`/`hi_o`/`lo_o`/`LLbit_o` all read 0 immediately, and reads of r1..r31 stay 0 after release.
- `$0` protection: write `wb_wd`=0, `wb_wdata`=32'hDEADBEEF, `wb_wreg`=1 → `raddr1`=0 returns 0 in the same cycle and afterwards.
- Bypass: write r5=32'h12345678 while `raddr1`=`raddr2`=5 and `re`=1 → both ports give 32'h12345678 in the same cycle when `WB_BYPASS_EN` is defined; without it they give the old value, then the new value next cycle.
- HI/LO: `wb_whilo`=1 with hi=32'hAAAA0000, lo=32'h0000BBBB → `hi_o`/`lo_o` show those values; with `wb_whilo`=0 and new data applied, the values are unchanged.
- LLbit priority:
  - `wb_LLbit_we`=1, value=1 → `LLbit_o`=1.
  - Next cycle, `flush`=1 together with `wb_LLbit_we`=1, value=1 → `LLbit_o`=0.
- Read enable: `re1`=0 with `raddr1`=7 holding 32'hCAFEF00D → `rdata1`=0; `re1`=1 → 32'hCAFEF00D.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-wide types and constants used by the writeback commit slice.
package cpu_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [31:0]           word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG  = 5'd0;
  localparam word_t     WORD_ZERO = 32'h0;

endpackage : cpu_pkg

// File: rtl/regfile_2r1w.sv
// Two-read / one-write general-purpose register file.
// $0 is never written and always reads as zero; reads are gated by enables.
// Optional macro WB_BYPASS_EN: a read that hits the address being written this
// cycle returns the write data (write-through) instead of the stored value.
module regfile_2r1w
  import cpu_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned DW    = 32,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re1,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic          re2,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2
);

  logic [DW-1:0] regs [NREGS];
  logic          wr_ok;

  assign wr_ok = we && (waddr != AW'(ZERO_REG));

  // Commit one GPR write per edge; $0 is masked so it stays at its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is cleared by reset because software relies on every
      // GPR reading zero after reset; that makes it flops, not an SRAM macro.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      // NOTE: state updates use non-blocking assignment so every flop samples
      // pre-edge values regardless of block ordering.
      regs[waddr] <= wdata;
    end
  end

  // Read port 1: enable and $0 masking first, then optional write-through.
  always_comb begin
    // NOTE: default first so every path assigns rdata1 and no latch is inferred.
    rdata1 = '0;
    if (re1 && (raddr1 != AW'(ZERO_REG))) begin
`ifdef WB_BYPASS_EN
      if (!rst_n)                         rdata1 = '0;
      else if (wr_ok && waddr == raddr1)  rdata1 = wdata;
      else                                rdata1 = regs[raddr1];
`else
      rdata1 = regs[raddr1];
`endif
    end
  end

  // Read port 2: identical structure to port 1.
  always_comb begin
    rdata2 = '0;
    if (re2 && (raddr2 != AW'(ZERO_REG))) begin
`ifdef WB_BYPASS_EN
      if (!rst_n)                         rdata2 = '0;
      else if (wr_ok && waddr == raddr2)  rdata2 = wdata;
      else                                rdata2 = regs[raddr2];
`else
      rdata2 = regs[raddr2];
`endif
    end
  end

endmodule : regfile_2r1w

// File: rtl/wb_commit.sv
// Writeback commit: consumer end of MEM/WB. Owns the GPR file (via
// regfile_2r1w), the HI/LO pair and the LLbit.
// Optional macro WB_BYPASS_EN: HI/LO/LLbit read-outs and both GPR read ports
// show the value being committed this cycle; otherwise they show storage.
module wb_commit
  import cpu_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned DW    = 32,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] wb_wd,
  input  logic          wb_wreg,
  input  logic [DW-1:0] wb_wdata,
  input  logic          wb_whilo,
  input  logic [DW-1:0] wb_hi,
  input  logic [DW-1:0] wb_lo,
  input  logic          wb_LLbit_we,
  input  logic          wb_LLbit_value,
  input  logic          flush,
  input  logic          re1,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic          re2,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o,
  output logic          LLbit_o
);

  logic [DW-1:0] hi_q;
  logic [DW-1:0] lo_q;
  logic          llbit_q;
  logic          llbit_d;

  regfile_2r1w #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_wreg),
    .waddr  (wb_wd),
    .wdata  (wb_wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  // Next LLbit: a flush always breaks the link, even against a same-cycle set.
  always_comb begin
    llbit_d = llbit_q;
    if (flush)            llbit_d = 1'b0;
    else if (wb_LLbit_we) llbit_d = wb_LLbit_value;
  end

  // HI and LO commit together; there is no partial write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wb_whilo) begin
      hi_q <= wb_hi;
      lo_q <= wb_lo;
    end
  end

  // LLbit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) llbit_q <= 1'b0;
    else        llbit_q <= llbit_d;
  end

`ifdef WB_BYPASS_EN
  // Write-through read-outs; forced to zero while reset is held.
  always_comb begin
    hi_o    = '0;
    lo_o    = '0;
    LLbit_o = 1'b0;
    if (rst_n) begin
      hi_o    = wb_whilo ? wb_hi : hi_q;
      lo_o    = wb_whilo ? wb_lo : lo_q;
      LLbit_o = llbit_d;
    end
  end
`else
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign LLbit_o = llbit_q;
`endif

endmodule : wb_commit

// File: tb/tb_wb_commit.sv
// Directed self-checking bench for wb_commit. Expectations adapt to whether
// WB_BYPASS_EN is defined for the build.
`timescale 1ns/1ps
module tb_wb_commit;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        wb_LLbit_we;
  logic        wb_LLbit_value;
  logic        flush;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        LLbit_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_commit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wb_wd          (wb_wd),
    .wb_wreg        (wb_wreg),
    .wb_wdata       (wb_wdata),
    .wb_whilo       (wb_whilo),
    .wb_hi          (wb_hi),
    .wb_lo          (wb_lo),
    .wb_LLbit_we    (wb_LLbit_we),
    .wb_LLbit_value (wb_LLbit_value),
    .flush          (flush),
    .re1            (re1),
    .raddr1         (raddr1),
    .rdata1         (rdata1),
    .re2            (re2),
    .raddr2         (raddr2),
    .rdata2         (rdata2),
    .hi_o           (hi_o),
    .lo_o           (lo_o),
    .LLbit_o        (LLbit_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs and samples sit 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bundle();
    wb_wd = '0; wb_wreg = 0; wb_wdata = '0;
    wb_whilo = 0; wb_hi = '0; wb_lo = '0;
    wb_LLbit_we = 0; wb_LLbit_value = 0; flush = 0;
  endtask

  task automatic write_gpr(input logic [4:0] a, input logic [31:0] d);
    wb_wd = a; wb_wreg = 1; wb_wdata = d;
    tick();
    wb_wreg = 0; wb_wd = '0; wb_wdata = '0;
  endtask

  initial begin
    idle_bundle();
    re1 = 1; raddr1 = 5'd5; re2 = 1; raddr2 = 5'd7;
    rst_n = 0;
    #1;
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_rdata2", rdata2, 32'h0);
    check("rst_hi", hi_o, 32'h0);
    check("rst_lo", lo_o, 32'h0);
    check("rst_llbit", {31'd0, LLbit_o}, 32'h0);
    @(negedge clk);
    rst_n = 1;
    tick();

    // $0 writes are discarded.
    raddr1 = 5'd0;
    wb_wd = 5'd0; wb_wreg = 1; wb_wdata = 32'hDEADBEEF;
    #1;
    check("r0_same", rdata1, 32'h0);
    tick();
    wb_wreg = 0; wb_wdata = '0;
    #1;
    check("r0_after", rdata1, 32'h0);

    // Both ports hit the register being written.
    raddr1 = 5'd5; raddr2 = 5'd5;
    wb_wd = 5'd5; wb_wreg = 1; wb_wdata = 32'h12345678;
    #1;
    check("byp_p1_same", rdata1, BYP ? 32'h12345678 : 32'h0);
    check("byp_p2_same", rdata2, BYP ? 32'h12345678 : 32'h0);
    tick();
    wb_wreg = 0; wb_wd = '0; wb_wdata = '0;
    #1;
    check("byp_p1_next", rdata1, 32'h12345678);
    check("byp_p2_next", rdata2, 32'h12345678);

    // Read enable gating.
    write_gpr(5'd7, 32'hCAFEF00D);
    raddr1 = 5'd7; re1 = 0;
    #1;
    check("re1_off", rdata1, 32'h0);
    re1 = 1;
    #1;
    check("re1_on", rdata1, 32'hCAFEF00D);
    raddr2 = 5'd7; re2 = 0;
    #1;
    check("re2_off", rdata2, 32'h0);
    re2 = 1;
    #1;
    check("re2_on", rdata2, 32'hCAFEF00D);

    // HI/LO together with an independent GPR write.
    wb_whilo = 1; wb_hi = 32'hAAAA0000; wb_lo = 32'h0000BBBB;
    wb_wd = 5'd9; wb_wreg = 1; wb_wdata = 32'h00000099;
    #1;
    check("hi_same", hi_o, BYP ? 32'hAAAA0000 : 32'h0);
    check("lo_same", lo_o, BYP ? 32'h0000BBBB : 32'h0);
    tick();
    wb_whilo = 0; wb_hi = 32'h11111111; wb_lo = 32'h22222222;
    wb_wreg = 0; wb_wd = '0; wb_wdata = '0;
    raddr2 = 5'd9;
    #1;
    check("hi_held", hi_o, 32'hAAAA0000);
    check("lo_held", lo_o, 32'h0000BBBB);
    check("r9_with_hilo", rdata2, 32'h00000099);
    tick();
    check("hi_held2", hi_o, 32'hAAAA0000);
    check("lo_held2", lo_o, 32'h0000BBBB);
    wb_hi = '0; wb_lo = '0;

    // LLbit set, then flush wins over a simultaneous set.
    wb_LLbit_we = 1; wb_LLbit_value = 1;
    #1;
    check("ll_set_same", {31'd0, LLbit_o}, BYP ? 32'h1 : 32'h0);
    tick();
    wb_LLbit_we = 0; wb_LLbit_value = 0;
    #1;
    check("ll_set", {31'd0, LLbit_o}, 32'h1);
    flush = 1; wb_LLbit_we = 1; wb_LLbit_value = 1;
    #1;
    check("ll_flush_same", {31'd0, LLbit_o}, BYP ? 32'h0 : 32'h1);
    tick();
    flush = 0; wb_LLbit_we = 0; wb_LLbit_value = 0;
    #1;
    check("ll_flush", {31'd0, LLbit_o}, 32'h0);
    // Set again, then clear via a plain write of 0.
    wb_LLbit_we = 1; wb_LLbit_value = 1; tick();
    wb_LLbit_we = 1; wb_LLbit_value = 0; tick();
    wb_LLbit_we = 0;
    check("ll_clear_we", {31'd0, LLbit_o}, 32'h0);
    wb_LLbit_we = 1; wb_LLbit_value = 1; tick();
    wb_LLbit_we = 0; wb_LLbit_value = 0;

    // Back-to-back writes to one register: last edge wins.
    write_gpr(5'd3, 32'h00000001);
    write_gpr(5'd3, 32'h00000002);
    raddr1 = 5'd3;
    #1;
    check("b2b_last", rdata1, 32'h00000002);

    // An all-zero bundle leaves every piece of state unchanged.
    idle_bundle();
    tick(); tick();
    raddr1 = 5'd5; raddr2 = 5'd7;
    #1;
    check("bubble_r5", rdata1, 32'h12345678);
    check("bubble_r7", rdata2, 32'hCAFEF00D);
    check("bubble_hi", hi_o, 32'hAAAA0000);
    check("bubble_ll", {31'd0, LLbit_o}, 32'h1);

    // Asynchronous reset mid-cycle with a write pending across the edge.
    @(negedge clk);
    #2;
    wb_wd = 5'd10; wb_wreg = 1; wb_wdata = 32'h00000055;
    wb_whilo = 1; wb_hi = 32'h0F0F0F0F; wb_lo = 32'hF0F0F0F0;
    wb_LLbit_we = 1; wb_LLbit_value = 1;
    rst_n = 0;
    #1;
    check("arst_rdata1", rdata1, 32'h0);
    check("arst_rdata2", rdata2, 32'h0);
    check("arst_hi", hi_o, 32'h0);
    check("arst_lo", lo_o, 32'h0);
    check("arst_llbit", {31'd0, LLbit_o}, 32'h0);
    tick();
    idle_bundle();
    @(negedge clk);
    rst_n = 1;
    #1;
    check("post_hi", hi_o, 32'h0);
    check("post_lo", lo_o, 32'h0);
    check("post_llbit", {31'd0, LLbit_o}, 32'h0);
    for (int r = 1; r < 32; r++) begin
      raddr1 = 5'(r); raddr2 = 5'(r);
      #1;
      check($sformatf("post_p1_r%0d", r), rdata1, 32'h0);
      check($sformatf("post_p2_r%0d", r), rdata2, 32'h0);
    end

    // First edge after release accepts a write.
    write_gpr(5'd31, 32'h80000001);
    raddr1 = 5'd31;
    #1;
    check("first_write", rdata1, 32'h80000001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule : tb_wb_commit
